simple_mem_responder: RTL and testbench
=======================================

SIMPLE_MEM_RESPONDER -- requirements
Module: simple_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of implemented 8-bit words (1..256).
REQ-002 Parameter WAIT_CYCLES, default 1, extra access latency in clocks (0..15).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  initiator presents a request.
REQ-006 req_ready  out  1  responder can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  8  word address.
REQ-009 req_wdata  in  8  store data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  initiator consumes response.
REQ-012 rsp_rdata  out  8  load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  address >= DEPTH.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, WAIT, RESP; one outstanding request max.
REQ-016 req_ready = 1 only in IDLE; accept = req_valid & req_ready at a rising edge.
REQ-017 On accept: capture req_we, req_addr, req_wdata; next state RESP if WAIT_CYCLES = 0, else WAIT with counter loaded to WAIT_CYCLES-1.
REQ-018 WAIT: counter decrements each edge; at the edge where counter = 0, perform the access and go to RESP.
REQ-019 rsp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge (i.e. first visible in the cycle following that edge).
REQ-020 Access at transition into RESP: load -> rsp_rdata = mem[addr]; store -> mem[addr] = wdata, rsp_rdata = 0.
REQ-021 Address >= DEPTH: no memory write, rsp_rdata = 0, rsp_err = 1; otherwise rsp_err = 0.
REQ-022 RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_valid & rsp_ready at an edge; then -> IDLE, rsp_valid = 0.
REQ-023 rsp_ready asserted early (before rsp_valid) has no effect; no response is dropped or duplicated.
REQ-024 req_* inputs are ignored outside IDLE; changes to them after accept do not affect the in-flight request.
REQ-025 Minimum request spacing: WAIT_CYCLES+2 cycles when rsp_ready is held high.
REQ-026 Load following a store to the same address returns the stored value.
REQ-027 Memory array is not reset; contents are preserved across reset.

Reset
REQ-028 reset low (asynchronously): state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, req_ready = 1 once reset is high.
REQ-029 Reset asserted in WAIT or RESP abandons the request; a store still in WAIT is not written, and no response is issued after reset.
REQ-030 First accept occurs no earlier than the first rising edge after reset deasserts.

Verification
REQ-031 WAIT_CYCLES=1: store 0x5A to 0x10, then load 0x10 -> each rsp_valid arrives 2 edges after its accept; load rsp_rdata = 0x5A, rsp_err = 0.
REQ-032 WAIT_CYCLES=0, rsp_ready tied high, req_valid held high -> loads accepted every 2nd cycle, each rsp_valid high for exactly 1 cycle.
REQ-033 Backpressure: rsp_ready low for 5 cycles during RESP -> rsp_valid/rsp_rdata stable for all 5, req_ready = 0, no new accept.
REQ-034 DEPTH=16: store 0xFF to 0x20 -> rsp_err = 1; load 0x20 -> rsp_rdata = 0, rsp_err = 1; mem[0x00] unchanged.
REQ-035 WAIT_CYCLES=3: store 0xAA to 0x05 (old value 0x11); assert reset in 2nd WAIT cycle -> rsp_valid stays 0; after reset, load 0x05 returns 0x11.
REQ-036 Address wrap boundary: store to 0xFF and 0x00 (DEPTH=256), load both -> values returned independently, no aliasing.

Source files
------------

// File: rtl/simple_mem_responder.sv
// rtl/simple_mem_responder.sv - single-outstanding request/response memory responder with fixed access latency
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   req_valid  initiator presents a request
//   req_ready  high only in IDLE (and out of reset)
//   req_we     1 = store, 0 = load
//   req_addr   word address
//   req_wdata  store data
//   rsp_valid  response available (RESP state)
//   rsp_ready  initiator consumes response
//   rsp_rdata  load data, 0 for stores and errors
//   rsp_err    address was >= DEPTH
//   busy       high in any state other than IDLE
module simple_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;

    logic       cap_we;
    logic [7:0] cap_addr;
    logic [7:0] cap_wdata;

    logic       accept;
    logic       do_access;
    logic       acc_we;
    logic [7:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       acc_in_range;
    logic [7:0] acc_rdata;

    // Contents survive reset, so the array has no reset branch.
    logic [7:0] mem [0:DEPTH-1];

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx  = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx  = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // With zero wait the access happens on the accepting edge itself, so the
    // live request fields are used; otherwise the captured copy is used.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = cap_we;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
        end
    end

    assign acc_in_range = ({1'b0, acc_addr} < 9'(DEPTH));
    assign acc_rdata    = (!acc_we && acc_in_range) ? mem[acc_addr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_access && acc_we && acc_in_range) begin
            mem[acc_addr[AW-1:0]] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 8'h00;
            cap_wdata <= 8'h00;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (do_access) begin
                rsp_rdata <= acc_rdata;
                rsp_err   <= !acc_in_range;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= 8'h00;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simple_mem_responder.sv
// tb/tb_simple_mem_responder.sv - directed self-checking bench for simple_mem_responder
module tb_simple_mem_responder;

    logic            clk;
    logic [2:0]      rst_n;
    logic [2:0]      req_valid;
    logic [2:0]      req_ready;
    logic [2:0]      req_we;
    logic [2:0][7:0] req_addr;
    logic [2:0][7:0] req_wdata;
    logic [2:0]      rsp_valid;
    logic [2:0]      rsp_ready;
    logic [2:0][7:0] rsp_rdata;
    logic [2:0]      rsp_err;
    logic [2:0]      busy;

    int n_tests;
    int n_fail;

    // 0: DEPTH 256, WAIT 1   1: DEPTH 16, WAIT 0   2: DEPTH 256, WAIT 3
    simple_mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    simple_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    simple_mem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) u_c (
        .clk(clk), .reset(rst_n[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after a rising edge with instance i idle.
    task automatic do_req(input int i, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input int wait_c,
                          input logic [7:0] exp_rdata, input logic exp_err,
                          input string tag);
        int n;
        check({tag, "_ready"}, req_ready[i], 1);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        tick();
        // Scramble request fields after the accept; the in-flight request must not see them.
        req_valid[i] = 1'b0;
        req_we[i]    = ~we;
        req_addr[i]  = ~addr;
        req_wdata[i] = ~wdata;
        n = 1;
        while (!rsp_valid[i] && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, wait_c + 1);
        check({tag, "_rdata"}, rsp_rdata[i], exp_rdata);
        check({tag, "_err"}, rsp_err[i], exp_err);
        rsp_ready[i] = 1'b1;
        tick();
        rsp_ready[i] = 1'b0;
        check({tag, "_done"}, rsp_valid[i], 0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 3'b000;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;

        repeat (3) tick();
        check("rst_rsp_valid", rsp_valid[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_rdata", rsp_rdata[0], 0);
        check("rst_err", rsp_err[0], 0);
        rst_n = 3'b111;
        #1;
        check("rst_req_ready", req_ready[0], 1);
        tick();

        // Instance A, WAIT_CYCLES=1
        do_req(0, 1'b1, 8'h10, 8'h5A, 1, 8'h00, 1'b0, "a_st10");
        do_req(0, 1'b0, 8'h10, 8'h00, 1, 8'h5A, 1'b0, "a_ld10");

        // Backpressure: response held 5 cycles while a competing request waits.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 8'h10;
        tick();
        req_addr[0]  = 8'h00;
        tick();
        check("bp_first_valid", rsp_valid[0], 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_valid%0d", k), rsp_valid[0], 1);
            check($sformatf("bp_rdata%0d", k), rsp_rdata[0], 8'h5A);
            check($sformatf("bp_ready%0d", k), req_ready[0], 0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        check("bp_released", rsp_valid[0], 0);
        check("bp_idle", busy[0], 0);

        // Address boundary: 0xFF and 0x00 are distinct words.
        do_req(0, 1'b1, 8'hFF, 8'hC3, 1, 8'h00, 1'b0, "a_stFF");
        do_req(0, 1'b1, 8'h00, 8'h3C, 1, 8'h00, 1'b0, "a_st00");
        do_req(0, 1'b0, 8'hFF, 8'h00, 1, 8'hC3, 1'b0, "a_ldFF");
        do_req(0, 1'b0, 8'h00, 8'h00, 1, 8'h3C, 1'b0, "a_ld00");

        // Instance B, DEPTH=16, WAIT_CYCLES=0
        do_req(1, 1'b1, 8'h00, 8'h77, 0, 8'h00, 1'b0, "b_st00");
        do_req(1, 1'b1, 8'h20, 8'hFF, 0, 8'h00, 1'b1, "b_st20_err");
        do_req(1, 1'b0, 8'h20, 8'h00, 0, 8'h00, 1'b1, "b_ld20_err");
        do_req(1, 1'b0, 8'h00, 8'h00, 0, 8'h77, 1'b0, "b_ld00_kept");
        do_req(1, 1'b1, 8'h01, 8'h42, 0, 8'h00, 1'b0, "b_st01");

        // Streaming: req_valid and rsp_ready held high, accept every 2nd cycle.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 8'h01;
        rsp_ready[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("stream_valid%0d", k), rsp_valid[1], (k % 2 == 0) ? 1 : 0);
            check($sformatf("stream_rdata%0d", k), rsp_rdata[1], (k % 2 == 0) ? 8'h42 : 8'h00);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
        tick();
        check("stream_end_idle", busy[1], 0);

        // Instance C, WAIT_CYCLES=3: reset abandons a store still waiting.
        do_req(2, 1'b1, 8'h05, 8'h11, 3, 8'h00, 1'b0, "c_st05_init");
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 8'h05;
        req_wdata[2] = 8'hAA;
        tick();
        req_valid[2] = 1'b0;
        check("c_in_wait", busy[2], 1);
        tick();
        rst_n[2] = 1'b0;
        #1;
        check("c_rst_busy", busy[2], 0);
        check("c_rst_valid", rsp_valid[2], 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("c_in_rst_valid%0d", k), rsp_valid[2], 0);
        end
        rst_n[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("c_post_rst_valid%0d", k), rsp_valid[2], 0);
            check($sformatf("c_post_rst_busy%0d", k), busy[2], 0);
        end
        do_req(2, 1'b0, 8'h05, 8'h00, 3, 8'h11, 1'b0, "c_ld05_old");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
